msk_frame_sync: RTL and testbench



---
 rtl/msk_pkg.sv | 22 ++
 rtl/sync_correlator.sv | 41 ++++
 rtl/msk_frame_sync.sv | 167 ++++++++++++++++
 tb/tb_msk_frame_sync.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_pkg.sv
// Shared definitions for the MSK frame synchroniser: state encoding,
// default sync word and the Hamming-weight helper used by the correlator.
package msk_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'b00,
      ST_CHECK  = 2'b01,
      ST_LOCK   = 2'b10
   } msk_state_t;

   localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h1ACFFC1D;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/sync_correlator.sv
// Bit shift register and registered Hamming distances of the last 32 bits
// against the sync word, in both polarities.
module sync_correlator
   import msk_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
   input  logic       rst,
   input  logic       clk,
   input  logic       bit_en,
   input  logic       din,
   output logic       eval_en,
   output logic       cur_bit,
   output logic [5:0] dist_p,
   output logic [5:0] dist_n
);

   logic [31:0] sr;
   logic [31:0] sr_next;

   assign sr_next = {sr[30:0], din};
   // Newest bit; valid together with the distances on the eval cycle.
   assign cur_bit = sr[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr      <= '0;
         dist_p  <= '0;
         dist_n  <= '0;
         eval_en <= 1'b0;
      end else begin
         eval_en <= bit_en;
         if (bit_en) begin
            sr     <= sr_next;
            dist_p <= popcount32(sr_next ^ SYNC_WORD);
            dist_n <= popcount32(~sr_next ^ SYNC_WORD);
         end
      end
   end

endmodule

// File: rtl/msk_frame_sync.sv
// Frame synchroniser: SEARCH/CHECK/LOCK sync tracking with flywheel,
// polarity resolution and MSB-first byte packing of the payload.
module msk_frame_sync
   import msk_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
   parameter int          FRAME_BYTES = 64,
   parameter int          SEARCH_ERR  = 0,
   parameter int          LOCK_ERR    = 2,
   parameter int          CONFIRM     = 2,
   parameter int          FLYWHEEL    = 3
) (
   input  logic       rst,
   input  logic       clk,
   input  logic       din,
   input  logic       bit_sync,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_start,
   output logic       frame_end,
   output logic       locked,
   output logic       invert,
   output logic [1:0] state
);

   localparam int FRAME_BITS = FRAME_BYTES * 8;
   localparam int LAST_BIT   = FRAME_BITS + 31;
   localparam int BCW        = $clog2(LAST_BIT + 1);

   localparam logic [BCW-1:0] LAST_B     = BCW'(LAST_BIT);
   localparam logic [BCW-1:0] PAY_END    = BCW'(FRAME_BITS);
   localparam logic [BCW-1:0] FIRST_BYTE = BCW'(7);
   localparam logic [BCW-1:0] FINAL_BYTE = BCW'(FRAME_BITS - 1);
   localparam logic [5:0]     SEARCH_LIM = 6'(SEARCH_ERR);
   localparam logic [5:0]     LOCK_LIM   = 6'(LOCK_ERR);
   localparam logic [3:0]     CONFIRM_L  = 4'(CONFIRM);
   localparam logic [3:0]     FLYWHEEL_L = 4'(FLYWHEEL);

   msk_state_t     state_q, state_d;
   logic           bs_q, bs_q2, bit_en;
   logic           eval_en, cur_bit, pay_bit;
   logic [5:0]     dist_p, dist_n, dist_sel;
   logic [BCW-1:0] bcnt;
   logic [2:0]     good_cnt, miss_cnt;
   logic [6:0]     byte_sr;
   logic           window, sync_ok, hit, hit_inv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bs_q  <= 1'b0;
         bs_q2 <= 1'b0;
      end else begin
         bs_q  <= bit_sync;
         bs_q2 <= bs_q;
      end
   end

   assign bit_en = bs_q & ~bs_q2;

   sync_correlator #(.SYNC_WORD(SYNC_WORD)) u_corr (
      .rst     (rst),
      .clk     (clk),
      .bit_en  (bit_en),
      .din     (din),
      .eval_en (eval_en),
      .cur_bit (cur_bit),
      .dist_p  (dist_p),
      .dist_n  (dist_n)
   );

   assign dist_sel = invert ? dist_n : dist_p;
   assign sync_ok  = (dist_sel <= LOCK_LIM);
   assign window   = (bcnt == LAST_B);
   assign pay_bit  = cur_bit ^ invert;
   assign state    = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_SEARCH;
      else     state_q <= state_d;
   end

   // All decisions are taken only on the eval cycle (one clk after bit_en).
   always_comb begin
      state_d = state_q;
      hit     = 1'b0;
      hit_inv = 1'b0;
      if (eval_en) begin
         case (state_q)
            ST_SEARCH: begin
               if (dist_p <= SEARCH_LIM) begin
                  hit     = 1'b1;
                  state_d = ST_CHECK;
               end else if (dist_n <= SEARCH_LIM) begin
                  hit     = 1'b1;
                  hit_inv = 1'b1;
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (window) begin
                  if (!sync_ok)
                     state_d = ST_SEARCH;
                  else if (({1'b0, good_cnt} + 4'd1) >= CONFIRM_L)
                     state_d = ST_LOCK;
               end
            end
            ST_LOCK: begin
               if (window && !sync_ok && (({1'b0, miss_cnt} + 4'd1) >= FLYWHEEL_L))
                  state_d = ST_SEARCH;
            end
            default: state_d = ST_SEARCH;
         endcase
      end
   end

   // data_valid is a single-clk strobe; data_out and the frame markers are
   // meaningful only while it is high. There is no backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         locked      <= 1'b0;
         invert      <= 1'b0;
         bcnt        <= '0;
         good_cnt    <= '0;
         miss_cnt    <= '0;
         byte_sr     <= '0;
      end else begin
         data_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         locked      <= (state_d == ST_LOCK);
         if (eval_en) begin
            if (state_q == ST_SEARCH) begin
               if (hit) begin
                  invert   <= hit_inv;
                  bcnt     <= '0;
                  good_cnt <= 3'd1;
                  miss_cnt <= '0;
               end
            end else begin
               bcnt <= window ? '0 : bcnt + BCW'(1);
               if (bcnt < PAY_END) begin
                  byte_sr <= {byte_sr[5:0], pay_bit};
                  if (bcnt[2:0] == 3'd7) begin
                     data_out    <= {byte_sr, pay_bit};
                     data_valid  <= 1'b1;
                     frame_start <= (bcnt == FIRST_BYTE);
                     frame_end   <= (bcnt == FINAL_BYTE);
                  end
               end
               if (window) begin
                  if (sync_ok) begin
                     miss_cnt <= '0;
                     if (state_q == ST_CHECK) good_cnt <= good_cnt + 3'd1;
                  end else if (state_q == ST_LOCK) begin
                     miss_cnt <= miss_cnt + 3'd1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_msk_frame_sync.sv
// Directed bench for msk_frame_sync with FRAME_BYTES=4 and a 32-clk bit period.
module tb_msk_frame_sync;

   localparam logic [31:0] SYNC = 32'h1ACFFC1D;
   localparam logic [31:0] PA   = 32'h11223344;
   localparam logic [31:0] PB   = 32'hA55A0FF0;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic       bit_sync;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_start;
   logic       frame_end;
   logic       locked;
   logic       invert;
   logic [1:0] state;

   int         checks = 0;
   int         failures = 0;
   logic [9:0] exp_q[$];
   int         dv_count = 0;
   bit         locked_seen = 1'b0;
   int         cyc = 0;
   int         rise_cyc = 0;
   logic       bs_prev = 1'b0;
   logic       inv_tx = 1'b0;

   msk_frame_sync #(
      .SYNC_WORD   (SYNC),
      .FRAME_BYTES (4),
      .SEARCH_ERR  (0),
      .LOCK_ERR    (2),
      .CONFIRM     (2),
      .FLYWHEEL    (3)
   ) dut (
      .rst         (rst),
      .clk         (clk),
      .din         (din),
      .bit_sync    (bit_sync),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .locked      (locked),
      .invert      (invert),
      .state       (state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (bit_sync === 1'b1 && bs_prev !== 1'b1) rise_cyc = cyc;
      bs_prev = bit_sync;
   end

   // scoreboard: every byte strobe is matched against the expected queue
   always @(negedge clk) begin
      logic [9:0] exp_v;
      if (locked === 1'b1) locked_seen = 1'b1;
      if (data_valid === 1'b1) begin
         dv_count = dv_count + 1;
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL byte_unexpected got byte=%h start=%b end=%b, required no output",
                     data_out, frame_start, frame_end);
         end else begin
            exp_v = exp_q.pop_front();
            if ({frame_start, frame_end, data_out} !== exp_v) begin
               failures = failures + 1;
               $display("FAIL byte got start=%b end=%b byte=%h, required start=%b end=%b byte=%h",
                        frame_start, frame_end, data_out, exp_v[9], exp_v[8], exp_v[7:0]);
            end
         end
         checks = checks + 1;
         if (cyc - rise_cyc != 2) begin
            failures = failures + 1;
            $display("FAIL latency got %0d clk, required 2 clk", cyc - rise_cyc);
         end
      end
   end

   // driver tasks
   task automatic apply_reset();
      rst = 1'b1;
      din = 1'b0;
      bit_sync = 1'b0;
      inv_tx = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      din = b ^ inv_tx;
      bit_sync = 1'b1;
      repeat (16) @(negedge clk);
      bit_sync = 1'b0;
      repeat (16) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic send_noise(input int n);
      for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
   endtask

   task automatic push_frame(input logic [31:0] p);
      for (int i = 0; i < 4; i++)
         exp_q.push_back({(i == 0), (i == 3), p[31 - 8*i -: 8]});
   endtask

   // test tasks
   task automatic test_reset();
      rst = 1'b1;
      din = 1'b0;
      bit_sync = 1'b0;
      repeat (3) @(negedge clk);
      checks = checks + 1;
      if (state !== 2'b00) begin failures = failures + 1; $display("FAIL reset_state got %b required 00", state); end
      checks = checks + 1;
      if ({data_valid, frame_start, frame_end, locked, invert} !== 5'b0) begin
         failures = failures + 1;
         $display("FAIL reset_flags got %b required 00000", {data_valid, frame_start, frame_end, locked, invert});
      end
      checks = checks + 1;
      if (data_out !== 8'h00) begin failures = failures + 1; $display("FAIL reset_data got %h required 00", data_out); end
      rst = 1'b0;
   endtask

   task automatic test_acquire(input logic inv, input int noise_bits);
      int d0;
      apply_reset();
      inv_tx = inv;
      d0 = dv_count;
      for (int f = 0; f < 4; f++) push_frame(PA);
      send_noise(noise_bits);
      checks = checks + 1;
      if (state !== 2'b00) begin failures = failures + 1; $display("FAIL acq_search got %b required 00", state); end
      send_word(SYNC);
      checks = checks + 1;
      if (state !== 2'b01 || locked !== 1'b0) begin
         failures = failures + 1;
         $display("FAIL acq_check got state=%b locked=%b required 01/0", state, locked);
      end
      checks = checks + 1;
      if (invert !== inv) begin failures = failures + 1; $display("FAIL acq_invert got %b required %b", invert, inv); end
      send_word(PA);
      send_word(SYNC);
      checks = checks + 1;
      if (state !== 2'b10 || locked !== 1'b1) begin
         failures = failures + 1;
         $display("FAIL acq_lock got state=%b locked=%b required 10/1", state, locked);
      end
      for (int f = 0; f < 3; f++) begin
         send_word(PA);
         if (f < 2) send_word(SYNC);
      end
      checks = checks + 1;
      if (dv_count - d0 != 16) begin failures = failures + 1; $display("FAIL acq_count got %0d required 16", dv_count - d0); end
      checks = checks + 1;
      if (exp_q.size() != 0) begin failures = failures + 1; $display("FAIL acq_pending got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_flywheel();
      logic [31:0] syncs [9];
      logic [1:0]  exp_st [9];
      logic [31:0] pay;
      apply_reset();
      syncs  = '{SYNC, SYNC, SYNC ^ 32'h3, SYNC ^ 32'h7, SYNC ^ 32'h7, SYNC,
                 SYNC ^ 32'h7, SYNC ^ 32'h7, SYNC ^ 32'h7};
      exp_st = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
      for (int k = 0; k < 8; k++) push_frame(k[0] ? PB : PA);
      send_noise(16);
      for (int k = 0; k < 9; k++) begin
         send_word(syncs[k]);
         checks = checks + 1;
         if (state !== exp_st[k]) begin
            failures = failures + 1;
            $display("FAIL fly_state_%0d got %b required %b", k, state, exp_st[k]);
         end
         pay = k[0] ? PB : PA;
         send_word(pay);
      end
      checks = checks + 1;
      if (locked !== 1'b0) begin failures = failures + 1; $display("FAIL fly_unlock got %b required 0", locked); end
      checks = checks + 1;
      if (exp_q.size() != 0) begin failures = failures + 1; $display("FAIL fly_pending got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_false_sync();
      int d0;
      apply_reset();
      locked_seen = 1'b0;
      d0 = dv_count;
      push_frame(PA);
      send_noise(16);
      send_word(SYNC);
      checks = checks + 1;
      if (state !== 2'b01) begin failures = failures + 1; $display("FAIL false_check got %b required 01", state); end
      send_word(PA);
      send_word(32'h55555555);
      checks = checks + 1;
      if (state !== 2'b00) begin failures = failures + 1; $display("FAIL false_search got %b required 00", state); end
      send_word(PB);
      send_word(PA);
      checks = checks + 1;
      if (dv_count - d0 != 4) begin failures = failures + 1; $display("FAIL false_count got %0d required 4", dv_count - d0); end
      checks = checks + 1;
      if (locked_seen !== 1'b0) begin failures = failures + 1; $display("FAIL false_locked got 1 required 0"); end
      checks = checks + 1;
      if (exp_q.size() != 0) begin failures = failures + 1; $display("FAIL false_pending got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_reset_abort();
      int d0;
      apply_reset();
      push_frame(PA);
      push_frame(PA);
      exp_q.push_back({2'b10, 8'h11});
      exp_q.push_back({2'b00, 8'h22});
      send_noise(16);
      send_word(SYNC); send_word(PA);
      send_word(SYNC); send_word(PA);
      send_word(SYNC);
      for (int i = 31; i >= 12; i--) send_bit(PA[i]);
      rst = 1'b1;
      #1;
      checks = checks + 1;
      if ({data_out, data_valid, frame_start, frame_end, locked, invert, state} !== 15'd0) begin
         failures = failures + 1;
         $display("FAIL abort_outputs got data=%h dv=%b fs=%b fe=%b lk=%b inv=%b st=%b required all 0",
                  data_out, data_valid, frame_start, frame_end, locked, invert, state);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      d0 = dv_count;
      for (int i = 11; i >= 0; i--) send_bit(PA[i]);
      checks = checks + 1;
      if (dv_count != d0 || state !== 2'b00) begin
         failures = failures + 1;
         $display("FAIL abort_quiet got bytes=%0d state=%b required 0/00", dv_count - d0, state);
      end
      push_frame(PB);
      push_frame(PB);
      send_word(SYNC);
      checks = checks + 1;
      if (state !== 2'b01) begin failures = failures + 1; $display("FAIL abort_reacq1 got %b required 01", state); end
      send_word(PB);
      send_word(SYNC);
      checks = checks + 1;
      if (state !== 2'b10) begin failures = failures + 1; $display("FAIL abort_reacq2 got %b required 10", state); end
      send_word(PB);
      checks = checks + 1;
      if (exp_q.size() != 0) begin failures = failures + 1; $display("FAIL abort_pending got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_stall();
      int d0;
      apply_reset();
      push_frame(PA);
      push_frame(PA);
      push_frame(PB);
      push_frame(PA);
      send_noise(16);
      send_word(SYNC); send_word(PA);
      send_word(SYNC); send_word(PA);
      send_word(SYNC);
      for (int i = 31; i >= 20; i--) send_bit(PB[i]);
      d0 = dv_count;
      repeat (1000) @(negedge clk);
      checks = checks + 1;
      if (dv_count != d0) begin failures = failures + 1; $display("FAIL stall_quiet got %0d bytes required 0", dv_count - d0); end
      checks = checks + 1;
      if (state !== 2'b10 || locked !== 1'b1) begin
         failures = failures + 1;
         $display("FAIL stall_state got state=%b locked=%b required 10/1", state, locked);
      end
      for (int i = 19; i >= 0; i--) send_bit(PB[i]);
      send_word(SYNC);
      send_word(PA);
      checks = checks + 1;
      if (state !== 2'b10) begin failures = failures + 1; $display("FAIL stall_resume got %b required 10", state); end
      checks = checks + 1;
      if (exp_q.size() != 0) begin failures = failures + 1; $display("FAIL stall_pending got %0d required 0", exp_q.size()); end
   endtask

   initial begin
      rst = 1'b1;
      din = 1'b0;
      bit_sync = 1'b0;
      test_reset();
      test_acquire(1'b0, 50);
      test_acquire(1'b1, 50);
      test_flywheel();
      test_false_sync();
      test_reset_abort();
      test_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
